// File: rtl/ram_arbiter_if.sv
// Purpose : bundles the two requester ports and the RAM port of ram_arbiter.
// Latency : n/a (wires only).
// Backpressure: requesters hold req until done; the RAM side has no stall.
//
// Port summary
//   r0_* / r1_* : req, we, addr, wdata in; gnt, done, rdata out (arbiter view)
//   ram_*       : ram_a, ram_we, ram_re, ram_wdata out; ram_rdata in
//   slave modport  -> the arbiter
//   master modport -> the environment (requesters + RAM)
interface ram_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 4
);
    // requester 0
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic          r0_done;
    logic [DW-1:0] r0_rdata;

    // requester 1
    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic          r1_done;
    logic [DW-1:0] r1_rdata;

    // RAM port
    logic [AW-1:0] ram_a;
    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_done, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_done, r1_rdata,
        output ram_a, ram_we, ram_re, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_done, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_done, r1_rdata,
        input  ram_a, ram_we, ram_re, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Purpose : two-requester round-robin arbiter in front of a single-port RAM.
// Latency : req sampled in IDLE at N -> gnt + RAM strobe at N+1 -> done at N+2.
// Backpressure: requesters hold req (level) until served; one access per 3 cycles max.
//
// Port summary
//   clk   : single clock, rising edge
//   rst   : asynchronous, active-high; forces IDLE and all outputs low at once
//   bus   : ram_arbiter_if.slave (requester 0/1 ports and RAM port)
module ram_arbiter #(
    parameter int AW = 16,
    parameter int DW = 4
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Fields of the access currently owning the RAM, latched at the IDLE
    // sampling edge. Nothing the requesters do afterwards can disturb them.
    logic          own_id;
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;

    // Read result; a write leaves it untouched.
    logic [DW-1:0] rdata;

    // Round-robin pointer: id of the requester granted most recently.
    // Reset value 1 makes requester 0 win the first tie.
    logic          last_id;

    // High for exactly the IDLE cycle following RSP. The requester just
    // served is ineligible then, so a req still held from the previous
    // access is not sampled a second time.
    logic          mask;

    // Arbitration
    logic          elig0;
    logic          elig1;
    logic          win_id;
    logic          capture;

    // Output drive
    logic          gnt0;
    logic          gnt1;
    logic          done0;
    logic          done1;
    logic          ram_we_c;
    logic          ram_re_c;

    //------------------------------------------------------------------
    // Eligibility and winner selection
    //------------------------------------------------------------------
    always_comb begin
        elig0   = bus.r0_req && !(mask && (last_id == 1'b0));
        elig1   = bus.r1_req && !(mask && (last_id == 1'b1));
        // On a tie the requester that was not granted last wins;
        // otherwise whichever one is eligible.
        if (elig0 && elig1) begin
            win_id = ~last_id;
        end else begin
            win_id = elig1;
        end
        capture = (state == IDLE) && (elig0 || elig1);
    end

    //------------------------------------------------------------------
    // FSM state register
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    //------------------------------------------------------------------
    // FSM next state and outputs. All strobes decode from the state
    // register only, so an asynchronous reset drops them immediately.
    //------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        ram_we_c  = 1'b0;
        ram_re_c  = 1'b0;

        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                ram_we_c  = own_we;
                ram_re_c  = !own_we;
                gnt0      = (own_id == 1'b0);
                gnt1      = (own_id == 1'b1);
                state_nxt = RSP;
            end
            RSP: begin
                done0     = (own_id == 1'b0);
                done1     = (own_id == 1'b1);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_id    <= 1'b0;
            own_we    <= 1'b0;
            own_addr  <= '0;
            own_wdata <= '0;
            rdata     <= '0;
            last_id   <= 1'b1;
            mask      <= 1'b0;
        end else begin
            if (capture) begin
                own_id    <= win_id;
                own_we    <= win_id ? bus.r1_we    : bus.r0_we;
                own_addr  <= win_id ? bus.r1_addr  : bus.r0_addr;
                own_wdata <= win_id ? bus.r1_wdata : bus.r0_wdata;
                last_id   <= win_id;
            end
            // The RAM answers combinationally while ram_re is high, so the
            // value is taken on the edge that closes ACC.
            if ((state == ACC) && !own_we) begin
                rdata <= bus.ram_rdata;
            end
            mask <= (state == RSP);
        end
    end

    //------------------------------------------------------------------
    // Output assignments
    //------------------------------------------------------------------
    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.r0_done   = done0;
    assign bus.r1_done   = done1;
    // Both requesters see the shared result register; it is only
    // meaningful while the matching done is high.
    assign bus.r0_rdata  = rdata;
    assign bus.r1_rdata  = rdata;
    assign bus.ram_a     = own_addr;
    assign bus.ram_wdata = own_wdata;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_re    = ram_re_c;

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose : self-checking bench for ram_arbiter with a behavioural RAM.
// Latency : expected grant/done cycles are derived from the sampling cycle.
// Backpressure: requesters hold req until their access has been sampled.
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port RAM: synchronous write, combinational read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_a] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = bus.ram_re ? mem[bus.ram_a] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    typedef struct {
        bit            id;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            gnt_cyc;
        int            done_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input bit req, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id == 1'b0) begin
            bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
        end else begin
            bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
        end
    endtask

    // Access sampled at the end of cycle n: grant in n+1, done in n+2.
    task automatic expect_acc(input bit id, input bit we, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                              input int n);
        exp_t x;
        x.id = id; x.we = we; x.addr = a; x.wdata = wd; x.rdata = rd;
        x.gnt_cyc = n + 1; x.done_cyc = n + 2;
        exp_q.push_back(x);
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cyc) begin
            step();
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Monitor: compares every grant and done against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.r0_gnt || bus.r1_gnt) begin
                chk("two_gnt", {31'd0, bus.r0_gnt & bus.r1_gnt}, 0);
                if (exp_q.size() == 0) begin
                    chk("unexp_gnt", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("gnt_id",  {31'd0, bus.r1_gnt}, {31'd0, e.id});
                    chk("gnt_cyc", cyc, e.gnt_cyc);
                    chk("ram_we",  {31'd0, bus.ram_we}, {31'd0, e.we});
                    chk("ram_re",  {31'd0, bus.ram_re}, {31'd0, !e.we});
                    chk("ram_a",   {16'd0, bus.ram_a}, {16'd0, e.addr});
                    if (e.we) chk("ram_wdata", {28'd0, bus.ram_wdata}, {28'd0, e.wdata});
                end
            end else begin
                chk("idle_strobe", {30'd0, bus.ram_we, bus.ram_re}, 0);
            end
            if (bus.r0_done || bus.r1_done) begin
                if (bus.r0_done) done0_cnt++;
                if (bus.r1_done) done1_cnt++;
                chk("two_done", {31'd0, bus.r0_done & bus.r1_done}, 0);
                if (exp_q.size() == 0) begin
                    chk("unexp_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_id",  {31'd0, bus.r1_done}, {31'd0, e.id});
                    chk("done_cyc", cyc, e.done_cyc);
                    if (!e.we) begin
                        chk("rdata", {28'd0, e.id ? bus.r1_rdata : bus.r0_rdata},
                            {28'd0, e.rdata});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        int d0;
        int d1;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);

        // Reset state
        rst = 1'b1;
        #2;
        chk("rst_gnt",    {30'd0, bus.r0_gnt, bus.r1_gnt}, 0);
        chk("rst_done",   {30'd0, bus.r0_done, bus.r1_done}, 0);
        chk("rst_strobe", {30'd0, bus.ram_we, bus.ram_re}, 0);
        chk("rst_ram_a",  {16'd0, bus.ram_a}, 0);
        chk("rst_rdata",  {24'd0, bus.r0_rdata, bus.r1_rdata}, 0);
        step(2);
        rst = 1'b0;
        step(2);

        // Single write; r0 inputs scrambled once sampled must not matter
        n = cyc;
        drive(0, 1, 1, 16'h1234, 4'hA);
        expect_acc(0, 1, 16'h1234, 4'hA, 4'h0, n);
        step();
        drive(0, 0, 0, 16'hFFFF, 4'h5);
        drain(10);
        step(2);

        // Read-back on r1
        n = cyc;
        drive(1, 1, 0, 16'h1234, 4'h0);
        expect_acc(1, 0, 16'h1234, 4'h0, 4'hA, n);
        step();
        drive(1, 0, 0, 16'h0000, 4'h0);
        drain(10);
        step(2);

        // Tie after reset, both held: alternation r0, r1, r0, r1 every 3 cycles
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        n = cyc;
        drive(0, 1, 1, 16'h0010, 4'h3);
        drive(1, 1, 0, 16'h1234, 4'h0);
        expect_acc(0, 1, 16'h0010, 4'h3, 4'h0, n);
        expect_acc(1, 0, 16'h1234, 4'h0, 4'hA, n + 3);
        expect_acc(0, 1, 16'h0010, 4'h3, 4'h0, n + 6);
        expect_acc(1, 0, 16'h1234, 4'h0, 4'hA, n + 9);
        step(11);
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        drain(10);
        step(2);

        // Held request: r0 alone for 12 cycles -> served every 4th cycle
        n  = cyc;
        d0 = done0_cnt;
        drive(0, 1, 0, 16'h0010, 4'h0);
        expect_acc(0, 0, 16'h0010, 4'h0, 4'h3, n);
        expect_acc(0, 0, 16'h0010, 4'h0, 4'h3, n + 4);
        expect_acc(0, 0, 16'h0010, 4'h0, 4'h3, n + 8);
        step(12);
        drive(0, 0, 0, '0, '0);
        drain(10);
        chk("held_dones", done0_cnt - d0, 3);
        step(2);

        // Reset in the middle of a write access
        d0 = done0_cnt;
        d1 = done1_cnt;
        n  = cyc;
        drive(0, 1, 1, 16'h0020, 4'h5);
        expect_acc(0, 1, 16'h0020, 4'h5, 4'h0, n);
        step();
        drive(0, 0, 0, '0, '0);
        #1;
        chk("abort_we_pre", {31'd0, bus.ram_we}, 1);
        rst = 1'b1;
        #1;
        chk("abort_we_async", {31'd0, bus.ram_we}, 0);
        chk("abort_gnt",      {30'd0, bus.r0_gnt, bus.r1_gnt}, 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step(3);
        chk("abort_no_done", (done0_cnt - d0) + (done1_cnt - d1), 0);
        chk("abort_mem", {28'd0, mem[16'h0020]}, 0);

        // Tie right after the abort goes to r0 again
        n = cyc;
        drive(0, 1, 1, 16'h0030, 4'h7);
        drive(1, 1, 0, 16'h0010, 4'h0);
        expect_acc(0, 1, 16'h0030, 4'h7, 4'h0, n);
        expect_acc(1, 0, 16'h0010, 4'h0, 4'h3, n + 3);
        step();
        drive(0, 0, 0, '0, '0);
        step(3);
        drive(1, 0, 0, '0, '0);
        drain(10);
        step(2);

        // Withdrawn request: r1_req pulses between two edges only
        d1 = done1_cnt;
        drive(1, 1, 0, 16'h0010, 4'h0);
        #3;
        drive(1, 0, 0, 16'h0010, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wd_gnt",    {31'd0, bus.r1_gnt}, 0);
            chk("wd_strobe", {30'd0, bus.ram_we, bus.ram_re}, 0);
        end
        chk("wd_no_done", done1_cnt - d1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning RAM address width.
REQ-002 SHALL have parameter DW, default 4, meaning RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports r0_req / r1_req  input  1  access request from requester 0 / 1 (level).
REQ-006 SHALL have ports r0_we / r1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports r0_addr / r1_addr  input  AW  access address.
REQ-008 SHALL have ports r0_wdata / r1_wdata  input  DW  write data.
REQ-009 SHALL have ports r0_gnt / r1_gnt  output  1  requester owns the RAM this cycle.
REQ-010 SHALL have ports r0_done / r1_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports r0_rdata / r1_rdata  output  DW  read result, valid while the matching done is high.
REQ-012 SHALL have port ram_a  output  AW  RAM address.
REQ-013 SHALL have ports ram_we / ram_re  output  1  active-high RAM write / read strobes.
REQ-014 SHALL have port ram_wdata  output  DW  RAM write data.
REQ-015 SHALL have port ram_rdata  input  DW  RAM read data, combinational from ram_a while ram_re is high.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, RSP; ACC and RSP each last exactly one cycle.
REQ-017 SHALL, in IDLE with at least one eligible request, register the winner's id, we, addr and wdata and move to ACC; with no eligible request, stay in IDLE.
REQ-018 SHALL arbitrate round-robin: with both requests eligible, the requester not served last wins; after reset requester 0 wins the first tie.
REQ-019 SHALL treat as ineligible, for the single IDLE cycle after its RSP, the requester just served, so that a held req is not double-served.
REQ-020 SHALL, in ACC, drive ram_a and ram_wdata from the registered fields, assert ram_we for a write or ram_re for a read, and assert the winner's gnt.
REQ-021 SHALL capture ram_rdata at the end of ACC for reads; for writes, the rdata register keeps its previous value.
REQ-022 SHALL, in RSP, pulse the winner's done for one cycle with rdata valid, then return to IDLE.
REQ-023 SHALL drive ram_we, ram_re, both gnt and both done low in every state other than those in REQ-020 and REQ-022; never both gnt at once.
REQ-024 SHALL give latency: req first sampled in IDLE at cycle N -> gnt and RAM strobe at N+1 -> done at N+2; back-to-back alternating service = 1 access per 3 cycles.
REQ-025 SHALL ignore changes to a requester's inputs after the IDLE sampling edge; req dropped before sampling is a withdrawn request with no access.
REQ-026 SHALL ignore req, we, addr and wdata of the non-owner during ACC and RSP.

Reset
REQ-027 SHALL, on rst high, immediately (without clock) force IDLE, all outputs 0, registered fields 0, and round-robin pointer to favour requester 0.
REQ-028 SHALL abort any in-flight ACC/RSP on reset, with no done issued and ram strobes dropped asynchronously.
REQ-029 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-030 SHALL be covered by: single write: r0 write addr 0x1234 data 0xA at N -> ram_we=1 with ram_a=0x1234, ram_wdata=0xA at N+1, r0_done at N+2, r1 outputs 0.
REQ-031 SHALL be covered by: read-back: r1 read 0x1234 with RAM holding 0xA -> ram_re at N+1, r1_done=1 and r1_rdata=0xA at N+2.
REQ-032 SHALL be covered by: tie after reset: r0 and r1 both requesting at N -> r0 served (done N+2), r1 served (gnt N+4, done N+5), order alternates thereafter.
REQ-033 SHALL be covered by: held request: r0_req held high for 12 cycles, r1 idle -> r0 served every 4th cycle (mask cycle), exactly 3 done pulses.
REQ-034 SHALL be covered by: reset mid-access: rst pulsed during ACC of a write -> ram_we falls without clock edge, no done, IDLE afterwards, next tie goes to r0.
REQ-035 SHALL be covered by: withdrawn request: r1_req high only between clock edges -> no gnt, no RAM strobe, no done.
